id_ex_decode_stage: RTL and testbench

- Decode/issue stage that drives the integer ALU's operand, function and opcode inputs.
- Accepts a 32-bit RV32I instruction plus register-file read data through a valid/ready handshake.
- Decodes aluOp, func, the immediate and the control flags, then holds them in a one-entry ID/EX pipeline register feeding the execute stage.
- Supports stall (backpressure), flush and bubble insertion.

---
 rtl/id_ex_decode_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_decode_stage.sv
// RV32I decode/issue stage: decodes ALU opcode, function, operands and control flags into a one-entry ID/EX register.
// Optional load-use interlock is compiled in when LOAD_USE_STALL_EN is defined.
module id_ex_decode_stage #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [width-1:0] rs1Data,
   input  logic [width-1:0] rs2Data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] dataA,
   output logic [width-1:0] dataB,
   output logic [width-1:0] storeData,
   output logic [3:0]       func,
   output logic [2:0]       aluOp,
   output logic [4:0]       rd,
   output logic             regWrite,
   output logic             memRead,
   output logic             memWrite,
   output logic             branch,
   output logic             illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [width-1:0] imm_i, imm_s, imm_u;
   logic [width-1:0] dec_a, dec_b, dec_store;
   logic [3:0]       dec_func;
   logic [2:0]       dec_alu_op;
   logic             dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_illegal;
   logic             reg_write_q, mem_read_q, mem_write_q, branch_q, illegal_q;
   logic             hazard, transfer;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // Immediates are sign-extended from their top instruction bit to the datapath width.
   always_comb begin
      imm_i       = {width{instr[31]}};
      imm_i[11:0] = instr[31:20];
      imm_s       = {width{instr[31]}};
      imm_s[11:0] = {instr[31:25], instr[11:7]};
      imm_u       = {width{instr[31]}};
      imm_u[31:0] = {instr[31:12], 12'b0};
   end

   always_comb begin
      dec_a         = '0;
      dec_b         = '0;
      dec_store     = '0;
      dec_func      = 4'b0000;
      dec_alu_op    = 3'b000;
      dec_reg_write = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_branch    = 1'b0;
      dec_illegal   = 1'b0;
      case (opcode)
         OP_R: begin
            dec_alu_op    = 3'b010;
            dec_func      = {instr[30], funct3};
            dec_a         = rs1Data;
            dec_b         = rs2Data;
            dec_reg_write = 1'b1;
         end
         OP_IMM: begin
            // instr[30] only distinguishes srai from srli; for other funct3 it is immediate data.
            dec_alu_op    = 3'b010;
            dec_func      = {(funct3 == 3'b101) & instr[30], funct3};
            dec_a         = rs1Data;
            dec_b         = imm_i;
            dec_reg_write = 1'b1;
         end
         OP_LOAD: begin
            dec_a         = rs1Data;
            dec_b         = imm_i;
            dec_mem_read  = 1'b1;
            dec_reg_write = 1'b1;
         end
         OP_STORE: begin
            dec_a         = rs1Data;
            dec_b         = imm_s;
            dec_store     = rs2Data;
            dec_mem_write = 1'b1;
         end
         OP_BRANCH: begin
            dec_alu_op = 3'b001;
            dec_a      = rs1Data;
            dec_b      = rs2Data;
            dec_branch = 1'b1;
         end
         OP_LUI: begin
            dec_b         = imm_u;
            dec_reg_write = 1'b1;
         end
         default: begin
            dec_alu_op  = 3'b111;
            dec_illegal = 1'b1;
         end
      endcase
      if (instr[11:7] == 5'd0) dec_reg_write = 1'b0;
   end

`ifdef LOAD_USE_STALL_EN
   logic uses_rs1, uses_rs2;

   assign uses_rs1 = (opcode == OP_R) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || (opcode == OP_BRANCH);
   assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   // Hold the consumer until the load has left, which leaves exactly one bubble behind it.
   assign hazard = out_valid && mem_read_q && (rd != 5'd0) &&
                   ((uses_rs1 && (instr[19:15] == rd)) || (uses_rs2 && (instr[24:20] == rd)));
`else
   assign hazard = 1'b0;
`endif

   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign transfer = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         dataA       <= '0;
         dataB       <= '0;
         storeData   <= '0;
         func        <= 4'b0000;
         aluOp       <= 3'b000;
         rd          <= 5'd0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         branch_q    <= 1'b0;
         illegal_q   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (transfer) begin
         out_valid   <= 1'b1;
         dataA       <= dec_a;
         dataB       <= dec_b;
         storeData   <= dec_store;
         func        <= dec_func;
         aluOp       <= dec_alu_op;
         rd          <= instr[11:7];
         reg_write_q <= dec_reg_write;
         mem_read_q  <= dec_mem_read;
         mem_write_q <= dec_mem_write;
         branch_q    <= dec_branch;
         illegal_q   <= dec_illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // A bubble must never leak stale control flags into execute.
   assign regWrite = out_valid & reg_write_q;
   assign memRead  = out_valid & mem_read_q;
   assign memWrite = out_valid & mem_write_q;
   assign branch   = out_valid & branch_q;
   assign illegal  = out_valid & illegal_q;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed testbench for id_ex_decode_stage; expectations are hand-decoded RV32I fields.
module tb_id_ex_decode_stage;

   localparam int width = 32;

   logic             clk = 1'b0;
   logic             reset, flush, in_valid, out_ready;
   logic             in_ready, out_valid;
   logic [31:0]      instr;
   logic [width-1:0] rs1Data, rs2Data;
   logic [width-1:0] dataA, dataB, storeData;
   logic [3:0]       func;
   logic [2:0]       aluOp;
   logic [4:0]       rd;
   logic             regWrite, memRead, memWrite, branch, illegal;
   logic [4:0]       flags;

   int vectors     = 0;
   int miscompares = 0;

   assign flags = {regWrite, memRead, memWrite, branch, illegal};

   always #5 clk = ~clk;

   id_ex_decode_stage #(.width(width)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .rs1Data(rs1Data), .rs2Data(rs2Data),
      .out_valid(out_valid), .out_ready(out_ready),
      .dataA(dataA), .dataB(dataB), .storeData(storeData),
      .func(func), .aluOp(aluOp), .rd(rd),
      .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
      .branch(branch), .illegal(illegal)
   );

   task automatic test_reset();
      reset = 1; flush = 0; in_valid = 0; out_ready = 0;
      instr = 0; rs1Data = 0; rs2Data = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({out_valid, flags, aluOp, func, rd} !== 18'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl got %h exp 0", {out_valid, flags, aluOp, func, rd});
      end
      vectors++;
      if ({dataA, dataB, storeData} !== 96'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_data got %h exp 0", {dataA, dataB, storeData});
      end
      reset = 0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_rtype();
      instr = 32'h40208033; rs1Data = 7; rs2Data = 3; in_valid = 1; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, func, rd, flags} !== {1'b1, 3'b010, 4'b1000, 5'd0, 5'b00000}) begin
         miscompares++;
         $display("[TB] FAIL sub_ctrl got %h exp %h", {out_valid, aluOp, func, rd, flags},
                  {1'b1, 3'b010, 4'b1000, 5'd0, 5'b00000});
      end
      vectors++;
      if ({dataA, dataB, storeData} !== {32'd7, 32'd3, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL sub_data got %h exp %h", {dataA, dataB, storeData}, {32'd7, 32'd3, 32'd0});
      end
   endtask

   task automatic test_itype();
      instr = 32'hFFF08293; rs1Data = 10; rs2Data = 32'h55; in_valid = 1; out_ready = 1;
      @(negedge clk);
      vectors++;
      if ({out_valid, aluOp, func, rd, flags} !== {1'b1, 3'b010, 4'b0000, 5'd5, 5'b10000}) begin
         miscompares++;
         $display("[TB] FAIL addi_ctrl got %h exp %h", {out_valid, aluOp, func, rd, flags},
                  {1'b1, 3'b010, 4'b0000, 5'd5, 5'b10000});
      end
      vectors++;
      if ({dataA, dataB, storeData} !== {32'd10, 32'hFFFFFFFF, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL addi_data got %h exp %h", {dataA, dataB, storeData},
                  {32'd10, 32'hFFFFFFFF, 32'd0});
      end
      instr = 32'h4030D293; rs1Data = 20;
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, func, rd, flags, dataA, dataB} !==
          {1'b1, 3'b010, 4'b1101, 5'd5, 5'b10000, 32'd20, 32'h00000403}) begin
         miscompares++;
         $display("[TB] FAIL srai got %h exp %h", {out_valid, aluOp, func, rd, flags, dataA, dataB},
                  {1'b1, 3'b010, 4'b1101, 5'd5, 5'b10000, 32'd20, 32'h00000403});
      end
   endtask

   task automatic test_store();
      instr = 32'h0020A423; rs1Data = 100; rs2Data = 32'hDEADBEEF; in_valid = 1; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, func, rd, flags} !== {1'b1, 3'b000, 4'b0000, 5'd8, 5'b00100}) begin
         miscompares++;
         $display("[TB] FAIL sw_ctrl got %h exp %h", {out_valid, aluOp, func, rd, flags},
                  {1'b1, 3'b000, 4'b0000, 5'd8, 5'b00100});
      end
      vectors++;
      if ({dataA, dataB, storeData} !== {32'd100, 32'd8, 32'hDEADBEEF}) begin
         miscompares++;
         $display("[TB] FAIL sw_data got %h exp %h", {dataA, dataB, storeData},
                  {32'd100, 32'd8, 32'hDEADBEEF});
      end
   endtask

   task automatic test_back_to_back();
      instr = 32'hFFFFF2B7; rs1Data = 32'h1234; rs2Data = 32'h99; in_valid = 1; out_ready = 1;
      @(negedge clk);
      vectors++;
      if ({out_valid, aluOp, func, rd, flags, dataA, dataB, storeData} !==
          {1'b1, 3'b000, 4'b0000, 5'd5, 5'b10000, 32'd0, 32'hFFFFF000, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL lui got %h", {out_valid, aluOp, func, rd, flags, dataA, dataB, storeData});
      end
      instr = 32'h00208463; rs1Data = 5; rs2Data = 6;
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, func, rd, flags, dataA, dataB, storeData} !==
          {1'b1, 3'b001, 4'b0000, 5'd8, 5'b00010, 32'd5, 32'd6, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL beq got %h", {out_valid, aluOp, func, rd, flags, dataA, dataB, storeData});
      end
   endtask

   task automatic test_illegal();
      instr = 32'h0000007F; rs1Data = 32'hAAAA; rs2Data = 32'hBBBB; in_valid = 1; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, flags} !== {1'b1, 3'b111, 5'b00001}) begin
         miscompares++;
         $display("[TB] FAIL illegal_ctrl got %h exp %h", {out_valid, aluOp, flags}, {1'b1, 3'b111, 5'b00001});
      end
      vectors++;
      if ({dataA, dataB, storeData} !== 96'd0) begin
         miscompares++;
         $display("[TB] FAIL illegal_data got %h exp 0", {dataA, dataB, storeData});
      end
      @(negedge clk);
      vectors++;
      if ({out_valid, flags} !== 6'd0) begin
         miscompares++;
         $display("[TB] FAIL retire got %h exp 0", {out_valid, flags});
      end
   endtask

   task automatic test_stall();
      instr = 32'hFFF08293; rs1Data = 10; rs2Data = 0; in_valid = 1; out_ready = 0;
      @(negedge clk);
      instr = 32'h123452B7; rs1Data = 0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({in_ready, out_valid, aluOp, rd, flags, dataA, dataB} !==
             {1'b0, 1'b1, 3'b010, 5'd5, 5'b10000, 32'd10, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("[TB] FAIL stall_hold[%0d] got %h", i, {in_ready, out_valid, aluOp, rd, flags, dataA, dataB});
         end
         @(negedge clk);
      end
      out_ready = 1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL stall_release got %b exp 1", in_ready);
      end
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, rd, flags, dataA, dataB} !==
          {1'b1, 3'b000, 5'd5, 5'b10000, 32'd0, 32'h12345000}) begin
         miscompares++;
         $display("[TB] FAIL stall_next got %h", {out_valid, aluOp, rd, flags, dataA, dataB});
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL stall_nodup got %b exp 0", out_valid);
      end
   endtask

   task automatic test_flush();
      instr = 32'h0000A183; rs1Data = 32'h40; rs2Data = 0; in_valid = 1; out_ready = 0;
      @(negedge clk);
      vectors++;
      if ({out_valid, flags} !== {1'b1, 5'b11000}) begin
         miscompares++;
         $display("[TB] FAIL flush_pre got %h exp %h", {out_valid, flags}, {1'b1, 5'b11000});
      end
      instr = 32'h00218233; rs1Data = 32'h11; rs2Data = 32'h22; flush = 1; out_ready = 1;
      @(negedge clk);
      flush = 0;
      vectors++;
      if ({out_valid, flags, in_ready} !== {1'b0, 5'b00000, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL flush_kill got %h exp %h", {out_valid, flags, in_ready}, {1'b0, 5'b00000, 1'b1});
      end
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, rd, flags, dataA, dataB} !==
          {1'b1, 3'b010, 5'd4, 5'b10000, 32'h11, 32'h22}) begin
         miscompares++;
         $display("[TB] FAIL flush_after got %h", {out_valid, aluOp, rd, flags, dataA, dataB});
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stall();
      instr = 32'h0020A423; rs1Data = 100; rs2Data = 32'hDEADBEEF; in_valid = 1; out_ready = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0; in_valid = 0;
      vectors++;
      if ({out_valid, flags, aluOp, func, rd, dataA, dataB, storeData} !== 114'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_stall got %h exp 0", {out_valid, flags, aluOp, func, rd, dataA, dataB, storeData});
      end
   endtask

   task automatic test_load_use();
      instr = 32'h0000A183; rs1Data = 32'h40; rs2Data = 0; in_valid = 1; out_ready = 1;
      @(negedge clk);
      vectors++;
      if ({out_valid, aluOp, rd, flags, dataA, dataB} !== {1'b1, 3'b000, 5'd3, 5'b11000, 32'h40, 32'd0}) begin
         miscompares++;
         $display("[TB] FAIL lw got %h", {out_valid, aluOp, rd, flags, dataA, dataB});
      end
      instr = 32'h00218233; rs1Data = 32'h11; rs2Data = 32'h22;
      #1;
`ifdef LOAD_USE_STALL_EN
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL hazard_block got %b exp 0", in_ready);
      end
      @(negedge clk);
      vectors++;
      if ({out_valid, flags, in_ready} !== {1'b0, 5'b00000, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL hazard_bubble got %h exp %h", {out_valid, flags, in_ready}, {1'b0, 5'b00000, 1'b1});
      end
`else
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL nohazard_ready got %b exp 1", in_ready);
      end
`endif
      @(negedge clk);
      in_valid = 0;
      vectors++;
      if ({out_valid, aluOp, func, rd, flags, dataA, dataB} !==
          {1'b1, 3'b010, 4'b0000, 5'd4, 5'b10000, 32'h11, 32'h22}) begin
         miscompares++;
         $display("[TB] FAIL add_issue got %h", {out_valid, aluOp, func, rd, flags, dataA, dataB});
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_store();
      test_back_to_back();
      test_illegal();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      test_load_use();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

endmodule
